// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ASIZE_DEF = 8;
    localparam int DSIZE_DEF = 16;

    // Arbiter state: normal priority arbitration, or port-1 burst lock.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Originator of a memory command, carried with each read to route its data back.
    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Two-stage read tag shift register: a tag entering with a read grant leaves two
// cycles later, exactly when the memory presents that read's data.
module rd_tag_pipe
    import dmem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage1;
    rd_tag_t stage2;

    // Shift the tag one stage per clock; clearing drops every in-flight read.
    always_ff @(posedge clk) begin
        // NOTE: the tag stages must be cleared on reset, otherwise a read that was in
        // flight when reset hit would produce a stray rvalid afterwards.
        if (clr) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= tag_in;
            stage2 <= stage1;
        end
    end

    assign tag_out = stage2;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous data memory.
// Port 0 (pipeline) has priority; port 1 (DMA) has a starvation guard and a
// bounded burst-lock mode. One registered memory command per cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ASIZE     = ASIZE_DEF,
    parameter int DSIZE     = DSIZE_DEF,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [ASIZE-1:0] p0_addr,
    input  logic [DSIZE-1:0] p0_wdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [ASIZE-1:0] p1_addr,
    input  logic [DSIZE-1:0] p1_wdata,
    input  logic             p1_lock,
    output logic             p0_gnt,
    output logic             p1_gnt,
    output logic             p0_rvalid,
    output logic             p1_rvalid,
    output logic [DSIZE-1:0] p0_rdata,
    output logic [DSIZE-1:0] p1_rdata,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [WW-1:0]    wait_cnt;
    logic [BW-1:0]    burst_cnt;
    logic             burst_mode;
    logic             any_gnt;
    logic             sel_we;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_wdata;
    logic             wen_q;
    logic             ren_q;
    logic [ASIZE-1:0] addr_q;
    logic [DSIZE-1:0] wdata_q;
    rd_tag_t          rd_tag_in;
    rd_tag_t          rd_tag_out;

    // Burst lock only applies while the DMA keeps p1_lock high; dropping it
    // returns this very cycle to normal arbitration.
    assign burst_mode = (state == ST_BURST) && p1_lock;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) state <= ST_ARB;
        else     state <= state_nxt;
    end

    // Next-state: enter burst on a locked p1 grant, leave when the lock drops.
    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        state_nxt = state;
        case (state)
            ST_ARB:   if (p1_gnt && p1_lock) state_nxt = ST_BURST;
            ST_BURST: if (!p1_lock)          state_nxt = ST_ARB;
            default:  state_nxt = ST_ARB;
        endcase
    end

    // Grant outputs: burst lock, else port 1 when starving or alone, else port 0.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (burst_mode) begin
                if (burst_cnt == BURST_MAX && p0_req) p0_gnt = 1'b1;
                else if (p1_req)                      p1_gnt = 1'b1;
            end else if (p1_req && (!p0_req || wait_cnt == WAIT_MAX)) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end
        end
    end

    // Starvation and burst-length counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            if (p1_req && !p1_gnt) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (state == ST_ARB) begin
                if (p1_gnt && p1_lock) burst_cnt <= BW'(1);
            end else if (!p1_lock || p0_gnt) begin
                burst_cnt <= '0;
            end else if (p1_gnt && burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_we    = p1_gnt ? p1_we    : p0_we;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

    // Register the granted command; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            wen_q   <= sel_we;
            ren_q   <= !sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end else begin
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
        end
    end

    // The memory bus is forced idle during reset so the memory can be loaded.
    assign mem_wen   = wen_q & ~rst;
    assign mem_ren   = ren_q & ~rst;
    assign mem_addr  = rst ? '0 : addr_q;
    assign mem_wdata = rst ? '0 : wdata_q;

    // Tag each read grant with its originator.
    always_comb begin
        rd_tag_in.valid = any_gnt && !sel_we;
        rd_tag_in.port  = p1_gnt ? PORT_1 : PORT_0;
    end

    rd_tag_pipe u_rd_tag_pipe (
        .clk     (clk),
        .clr     (rst),
        .tag_in  (rd_tag_in),
        .tag_out (rd_tag_out)
    );

    assign p0_rvalid = !rst && rd_tag_out.valid && (rd_tag_out.port == PORT_0);
    assign p1_rvalid = !rst && rd_tag_out.valid && (rd_tag_out.port == PORT_1);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural reference model.
module tb_dmem_arbiter;

    localparam int ASIZE     = 8;
    localparam int DSIZE     = 16;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [ASIZE-1:0] p0_addr, p1_addr;
    logic [DSIZE-1:0] p0_wdata, p1_wdata;
    logic             p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DSIZE-1:0] p0_rdata, p1_rdata;
    logic             mem_wen, mem_ren;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    dmem_arbiter #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous data memory behind the arbiter.
    logic [DSIZE-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-cycle expectations from the arbitration rules,
    // a shadow memory, and a queue of outstanding read responses.
    // ------------------------------------------------------------------
    typedef struct {
        int               due;
        logic             port;
        logic [DSIZE-1:0] data;
    } resp_t;

    resp_t            rq[$];
    logic [DSIZE-1:0] shadow [256];
    bit               in_burst  = 1'b0;
    int               p1_run    = 0;   // locked p1 grants since burst start / last p0 slot
    int               p1_starve = 0;   // consecutive cycles p1 asked and was denied
    logic             c_wen = 1'b0, c_ren = 1'b0, c_port = 1'b0;
    logic [ASIZE-1:0] c_addr  = '0;
    logic [DSIZE-1:0] c_wdata = '0;
    logic             e_g0 = 1'b0, e_g1 = 1'b0;

    initial begin : model
        logic             e_rv0, e_rv1;
        logic [DSIZE-1:0] e_rd0, e_rd1;
        resp_t            r;
        forever begin
            @(negedge clk);
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (!rst) begin
                if (in_burst && p1_lock) begin
                    if (p1_run >= MAX_BURST && p0_req) e_g0 = 1'b1;
                    else if (p1_req)                   e_g1 = 1'b1;
                end else if (p1_req && (!p0_req || p1_starve >= MAX_WAIT)) begin
                    e_g1 = 1'b1;
                end else if (p0_req) begin
                    e_g0 = 1'b1;
                end
            end

            e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
            if (rst) begin
                rq.delete();
            end else if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.port) begin e_rv1 = 1'b1; e_rd1 = r.data; end
                else        begin e_rv0 = 1'b1; e_rd0 = r.data; end
            end

            if (chk_en) begin
                check("p0_gnt",    p0_gnt,    e_g0);
                check("p1_gnt",    p1_gnt,    e_g1);
                check("p0_rvalid", p0_rvalid, e_rv0);
                check("p1_rvalid", p1_rvalid, e_rv1);
                check("p0_rdata",  p0_rdata,  e_rd0);
                check("p1_rdata",  p1_rdata,  e_rd1);
                check("mem_wen",   mem_wen,   rst ? 1'b0 : c_wen);
                check("mem_ren",   mem_ren,   rst ? 1'b0 : c_ren);
                check("mem_addr",  mem_addr,  rst ? '0 : c_addr);
                check("mem_wdata", mem_wdata, rst ? '0 : c_wdata);
            end

            // The command on the bus this cycle takes effect in memory order.
            if (!rst) begin
                if (c_wen) shadow[c_addr] = c_wdata;
                if (c_ren) rq.push_back('{due: cyc + 1, port: c_port, data: shadow[c_addr]});
            end

            if (rst) begin
                in_burst = 1'b0; p1_run = 0; p1_starve = 0;
                c_wen = 1'b0; c_ren = 1'b0; c_port = 1'b0; c_addr = '0; c_wdata = '0;
            end else begin
                if (e_g0 || e_g1) begin
                    c_wen   = e_g1 ? p1_we : p0_we;
                    c_ren   = !c_wen;
                    c_addr  = e_g1 ? p1_addr : p0_addr;
                    c_wdata = e_g1 ? p1_wdata : p0_wdata;
                    c_port  = e_g1;
                end else begin
                    c_wen = 1'b0;
                    c_ren = 1'b0;
                end
                if (p1_req && !e_g1) p1_starve++;
                else                 p1_starve = 0;
                if (in_burst && !p1_lock) begin
                    in_burst = 1'b0;
                end else if (in_burst) begin
                    if (e_g0)      p1_run = 0;
                    else if (e_g1) p1_run++;
                end else if (e_g1 && p1_lock) begin
                    in_burst = 1'b1;
                    p1_run   = 1;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        p1_lock = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [14:0]      burst_seq;
        logic [DSIZE-1:0] exp_d;
        int               p1_left;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem_rdata = '0;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk_en = 1'b1;

        // Reset: requests present but nothing granted, bus idle.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h12; p0_wdata = 16'hBEEF;
        p1_req = 1'b1; p1_addr = 8'h33;
        @(negedge clk);
        check("rst_p0_gnt", p0_gnt, 1'b0);
        check("rst_p1_gnt", p1_gnt, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_p0_rdata", p0_rdata, 16'h0000);
        tick();
        rst = 1'b0;
        p1_req = 1'b0;

        // Write 0x12 <- 0xBEEF, then read it back.
        @(negedge clk);
        check("wr_p0_gnt", p0_gnt, 1'b1);
        check("wr_p1_gnt", p1_gnt, 1'b0);
        tick();
        p0_we = 1'b0;
        @(negedge clk);
        check("rd_p0_gnt", p0_gnt, 1'b1);
        check("wr_mem_wen", mem_wen, 1'b1);
        check("wr_mem_addr", mem_addr, 8'h12);
        check("wr_mem_wdata", mem_wdata, 16'hBEEF);
        tick();
        p0_req = 1'b0;
        @(negedge clk);
        check("rd_mem_ren", mem_ren, 1'b1);
        check("rd_early_rvalid", p0_rvalid, 1'b0);
        tick();
        @(negedge clk);
        check("rd_p0_rvalid", p0_rvalid, 1'b1);
        check("rd_p0_rdata", p0_rdata, 16'hBEEF);
        check("rd_p1_rvalid", p1_rvalid, 1'b0);
        check("rd_p1_rdata", p1_rdata, 16'h0000);
        tick();

        // Both ports request continuously: p0 x4, then p1, repeating.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h20;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_p1_gnt", p1_gnt, (i % 5) == 4);
            check("starve_p0_gnt", p0_gnt, (i % 5) != 4);
            tick();
        end
        idle_inputs();
        tick();

        // Locked p1 burst of 10 reads with p0 requesting throughout.
        burst_seq = 15'b110_1111_1111_0000;  // bit i set: grant i goes to p1
        p0_req = 1'b1; p0_addr = 8'h40;
        p1_req = 1'b1; p1_addr = 8'h50; p1_lock = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("burst_p1_gnt", p1_gnt, burst_seq[i]);
            check("burst_p0_gnt", p0_gnt, !burst_seq[i]);
            tick();
        end
        p1_req = 1'b0; p1_lock = 1'b0;
        @(negedge clk);
        check("burst_exit_p0_gnt", p0_gnt, 1'b1);
        tick();
        idle_inputs();
        tick();
        tick();

        // Preload 0x01..0x04, then alternate p0/p1 reads back to back.
        for (int k = 0; k < 4; k++) begin
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'(k + 1); p0_wdata = 16'hA001 + 16'(k);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i < 4) begin
                if (i % 2 == 0) begin p0_req = 1'b1; p0_addr = 8'(i + 1); end
                else            begin p1_req = 1'b1; p1_addr = 8'(i + 1); end
            end
            @(negedge clk);
            if (i >= 2) begin
                exp_d = 16'hA001 + 16'(i - 2);
                check("alt_p0_rvalid", p0_rvalid, (i % 2) == 0);
                check("alt_p1_rvalid", p1_rvalid, (i % 2) == 1);
                check("alt_rdata", (i % 2 == 0) ? p0_rdata : p1_rdata, exp_d);
            end
            tick();
        end

        // Reset one cycle after a read grant drops the response.
        p0_req = 1'b1; p0_addr = 8'h03;
        @(negedge clk);
        check("rstmid_p0_gnt", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstmid_mem_ren", mem_ren, 1'b0);
        check("rstmid_mem_addr", mem_addr, 8'h00);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_no_rvalid", p0_rvalid, 1'b0);
        tick();
        p1_req = 1'b1; p1_addr = 8'h04; rst = 1'b1;
        @(negedge clk);
        check("rst_hold_p1_gnt", p1_gnt, 1'b0);
        tick();
        @(negedge clk);
        check("rst_hold2_p1_gnt", p1_gnt, 1'b0);
        check("rst_hold2_p1_rdata", p1_rdata, 16'h0000);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_p1_gnt", p1_gnt, 1'b1);
        tick();
        idle_inputs();
        tick();

        // Randomized traffic against the model.
        p1_left = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!p0_req || e_g0) begin
                p0_req   = ($urandom_range(0, 2) != 0);
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = 8'($urandom_range(0, 15));
                p0_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                p0_req = 1'b0;
            end
            if (e_g1 && p1_left > 0) p1_left--;
            if (!p1_req || e_g1) begin
                if (p1_left == 0 && $urandom_range(0, 5) == 0) p1_left = $urandom_range(1, 12);
                p1_req   = (p1_left > 0) || ($urandom_range(0, 2) == 0);
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = 8'($urandom_range(0, 15));
                p1_wdata = 16'($urandom);
            end
            p1_lock = (p1_left > 0) || ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
